// File: rtl/mips_mem_pkg.sv
// mips_mem_pkg: shared encodings and defaults for the unified memory arbiter
package mips_mem_pkg;
  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 16;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_BUSY = 2'd1, ST_DONE = 2'd2} state_t;
  typedef enum logic {OWN_IF = 1'b0, OWN_D = 1'b1} owner_t;
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (&v) ? v : v + 16'd1;
  endfunction
endpackage

// File: rtl/arb_starve_ctr.sv
// arb_starve_ctr: saturating count of data-won conflicts, sat flags forced fetch win
module arb_starve_ctr #(
  parameter int MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic sat
);
  logic [3:0] cnt;
  always_ff @(posedge clk)
    if (rst || clr) cnt <= '0;
    else if (inc && !sat) cnt <= cnt + 4'd1;
  assign sat = cnt == 4'(MAX);
endmodule

// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter: shares one variable-latency memory between fetch and load/store ports
// Define ARB_STATS_EN to add saturating grant/conflict statistics ports.
module unified_mem_arbiter
  import mips_mem_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_valid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              stall_if,
  output logic              stall_mem,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef ARB_STATS_EN
  ,
  output logic [15:0]       stat_if_grants,
  output logic [15:0]       stat_d_grants,
  output logic [15:0]       stat_conflicts
`endif
);
  state_t state;
  owner_t owner;
  logic sat, any_req, both, win_d, grant;
  assign any_req = if_req | d_req;
  assign both = if_req & d_req;
  // data wins conflicts until fetch has lost STARVE_MAX in a row
  assign win_d = d_req & ~(if_req & sat);
  assign grant = (state == ST_IDLE) & any_req;
  assign stall_if = if_req & ~if_valid;
  assign stall_mem = d_req & ~d_valid;
  arb_starve_ctr #(.MAX(STARVE_MAX)) u_starve (
    .clk (clk),
    .rst (rst),
    .inc (grant & both & win_d),
    .clr (grant & ~win_d),
    .sat (sat)
  );
  always_ff @(posedge clk)
    if (rst) begin
      state <= ST_IDLE;
      owner <= OWN_IF;
      mem_req <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      if_valid <= 1'b0;
      d_valid <= 1'b0;
      if_rdata <= '0;
      d_rdata <= '0;
    end else begin
      if_valid <= 1'b0;
      d_valid <= 1'b0;
      case (state)
        ST_IDLE: if (any_req) begin
          state <= ST_BUSY;
          owner <= win_d ? OWN_D : OWN_IF;
          mem_req <= 1'b1;
          mem_we <= win_d & d_we;
          mem_addr <= win_d ? d_addr : if_addr;
          mem_wdata <= win_d ? d_wdata : '0;
        end
        ST_BUSY: if (mem_ack) begin
          state <= ST_DONE;
          mem_req <= 1'b0;
          mem_we <= 1'b0;
          if (owner == OWN_IF) begin
            if_valid <= 1'b1;
            if_rdata <= mem_rdata;
          end else begin
            d_valid <= 1'b1;
            if (!mem_we) d_rdata <= mem_rdata;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
`ifdef ARB_STATS_EN
  always_ff @(posedge clk)
    if (rst) begin
      stat_if_grants <= '0;
      stat_d_grants <= '0;
      stat_conflicts <= '0;
    end else if (grant) begin
      if (win_d) stat_d_grants <= sat_inc16(stat_d_grants);
      else stat_if_grants <= sat_inc16(stat_if_grants);
      if (both) stat_conflicts <= sat_inc16(stat_conflicts);
    end
`endif
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// tb_unified_mem_arbiter: directed and randomized checks against a transaction-level model
module tb_unified_mem_arbiter;
  localparam int AW = 16, DW = 16, SMAX = 4;
  logic clk = 1'b0, rst = 1'b1;
  logic if_req = 1'b0, if_valid;
  logic [AW-1:0] if_addr = '0;
  logic [DW-1:0] if_rdata;
  logic d_req = 1'b0, d_we = 1'b0, d_valid;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0, d_rdata;
  logic stall_if, stall_mem, mem_req, mem_we, mem_ack = 1'b0;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata = '0;
`ifdef ARB_STATS_EN
  logic [15:0] stat_if_grants, stat_d_grants, stat_conflicts;
`endif
  int errors = 0, checks = 0, starve = 0;
  logic [DW-1:0] mem [256];
  logic [DW-1:0] exp_ifr = '0, exp_dr = '0;
  always #5 clk = ~clk;
  unified_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_valid(if_valid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_valid(d_valid), .d_rdata(d_rdata),
    .stall_if(stall_if), .stall_mem(stall_mem),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
`ifdef ARB_STATS_EN
    , .stat_if_grants(stat_if_grants), .stat_d_grants(stat_d_grants), .stat_conflicts(stat_conflicts)
`endif
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic new_d();
    d_req = 1'b1;
    d_we = 1'($urandom_range(0, 1));
    d_addr = AW'($urandom);
    d_wdata = DW'($urandom);
  endtask
  // one complete access: grant decided by the model, random ack latency, valid pulse checked
  task automatic serve(input int lat, input bit reissue);
    bit wd, we;
    logic [AW-1:0] a;
    logic [DW-1:0] wdat, rd;
    int n = 0;
    while (!mem_req && n < 8) begin step(); n++; end
    chk("mem_req_rise", 32'(mem_req), 32'd1);
    if (if_req && d_req) begin
      wd = starve < SMAX;
      starve = wd ? starve + 1 : 0;
    end else begin
      wd = d_req;
      if (!wd) starve = 0;
    end
    we = wd & d_we;
    a = wd ? d_addr : if_addr;
    wdat = wd ? d_wdata : '0;
    chk("grant_addr", 32'(mem_addr), 32'(a));
    chk("grant_we", 32'(mem_we), 32'(we));
    chk("grant_wdata", 32'(mem_wdata), 32'(wdat));
    for (int i = 0; i < lat; i++) begin
      step();
      chk("busy_hold_addr", 32'(mem_addr), 32'(a));
      chk("busy_req_valids", 32'({mem_req, if_valid, d_valid}), 32'b100);
    end
    mem_ack = 1'b1;
    rd = we ? DW'($urandom) : mem[a[7:0]];
    mem_rdata = rd;
    #1;
    chk("stall_pending", 32'({stall_if, stall_mem}), 32'({if_req, d_req}));
    step();
    mem_ack = 1'b0;
    if (we) mem[a[7:0]] = wdat;
    if (!wd) exp_ifr = rd;
    else if (!we) exp_dr = rd;
    chk("done_valids", 32'({if_valid, d_valid}), wd ? 32'b01 : 32'b10);
    chk("done_mem_req", 32'({mem_req, mem_we}), 32'b00);
    chk("if_rdata", 32'(if_rdata), 32'(exp_ifr));
    chk("d_rdata", 32'(d_rdata), 32'(exp_dr));
    if (wd) begin
      if (reissue) new_d();
      else d_req = 1'b0;
    end else if_req = 1'b0;
    if ($urandom_range(0, 3) == 0) begin
      mem_ack = 1'b1;
      mem_rdata = DW'($urandom);
    end
    step();
    mem_ack = 1'b0;
    chk("idle_valids", 32'({if_valid, d_valid, mem_req}), 32'b000);
  endtask
  initial begin
    int guard;
    for (int i = 0; i < 256; i++) mem[i] = DW'($urandom);
    step();
    step();
    chk("rst_ctrl", 32'({mem_req, mem_we, if_valid, d_valid}), 32'd0);
    chk("rst_data", {mem_addr, mem_wdata}, 32'd0);
    chk("rst_rdata", {if_rdata, d_rdata}, 32'd0);
    rst = 1'b0;
    step();
    // directed load at 0x0010, ack in cycle 2
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0010;
    #1 chk("ld_c0", 32'({stall_mem, mem_req}), 32'b10);
    step();
    chk("ld_c1", 32'({stall_mem, mem_req, mem_we}), 32'b110);
    chk("ld_c1_addr", 32'(mem_addr), 32'h0010);
    step();
    mem_ack = 1'b1; mem_rdata = 16'hBEEF;
    #1 chk("ld_c2", 32'({stall_mem, mem_req, d_valid}), 32'b110);
    step();
    mem_ack = 1'b0;
    chk("ld_c3", 32'({d_valid, stall_mem, mem_req}), 32'b100);
    chk("ld_c3_data", 32'(d_rdata), 32'hBEEF);
    exp_dr = 16'hBEEF;
    d_req = 1'b0;
    step();
    chk("ld_c4", 32'(d_valid), 32'd0);
    // reset while BUSY, then a late ack must be ignored
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0040;
    step();
    chk("rb_c1", 32'(mem_req), 32'd1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0; d_req = 1'b0;
    starve = 0; exp_dr = '0; exp_ifr = '0;
    chk("rb_c3", 32'({mem_req, if_valid, d_valid}), 32'd0);
`ifdef ARB_STATS_EN
    chk("rb_stats", {stat_if_grants, stat_d_grants}, 32'd0);
    chk("rb_conf", 32'(stat_conflicts), 32'd0);
`endif
    step();
    mem_ack = 1'b1; mem_rdata = 16'h5A5A;
    step();
    mem_ack = 1'b0;
    chk("rb_c5", 32'({mem_req, if_valid, d_valid}), 32'd0);
    chk("rb_c5_rdata", 32'(d_rdata), 32'd0);
    step();
    chk("rb_c6", 32'({mem_req, if_valid, d_valid}), 32'd0);
    // conflict: data first, then fetch
    if_req = 1'b1; if_addr = 16'h0004;
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0020;
    serve(1, 1'b0);
    serve(0, 1'b0);
`ifdef ARB_STATS_EN
    chk("st_grants", {stat_if_grants, stat_d_grants}, {16'd1, 16'd1});
    chk("st_conf", 32'(stat_conflicts), 32'd1);
`endif
    // starvation: fetch held while data keeps coming back
    if_req = 1'b1; if_addr = 16'h0100;
    new_d();
    for (int i = 0; i < SMAX; i++) serve(0, 1'b1);
    chk("starve_if_next", 32'(if_req & d_req), 32'd1);
    serve(1, 1'b0);
    serve(0, 1'b0);
    chk("starve_drained", 32'({if_req, d_req}), 32'd0);
    // randomized traffic
    for (int r = 0; r < 60; r++) begin
      int pick = $urandom_range(1, 3);
      if (pick[0]) begin if_req = 1'b1; if_addr = AW'($urandom); end
      if (pick[1]) new_d();
      guard = 0;
      while ((if_req || d_req) && guard < 20) begin
        serve($urandom_range(0, 3), guard < 6 && $urandom_range(0, 3) != 0);
        guard++;
      end
      chk("rand_drained", 32'({if_req, d_req}), 32'd0);
      if ($urandom_range(0, 1) == 1) step();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
